cve2_fetch_req_ctrl: RTL
========================

// Module: cve2_fetch_req_ctrl
// PURPOSE
//  Sequences instruction-memory fetches for the IF stage: issues word-aligned OBI requests,
//  tracks up to NUM_REQS outstanding transactions and forwards responses into the fetch FIFO.
//  On a branch it clears the FIFO and discards in-flight responses.
//  Sits between the IF-stage control (req/branch) and the fetch FIFO + instr bus.
// PARAMETERS
//  NUM_REQS  2  max outstanding bus transactions; must equal the fetch FIFO NUM_REQS (>=1)
// PORTS
//  clk_i           in   1         clock
//  rst_ni          in   1         async reset, active low
//  req_i           in   1         core wants instructions
//  branch_i        in   1         redirect fetch to addr_i (1-cycle pulse)
//  addr_i          in   32        branch target (halfword aligned)
//  busy_o          out  1         any transaction outstanding or instr_req_o high
//  fifo_clear_o    out  1         clear fetch FIFO (= branch_i)
//  fifo_busy_i     in   NUM_REQS  upper FIFO entry occupancy
//  fifo_valid_o    out  1         push response into FIFO
//  fifo_addr_o     out  32        FIFO restart address (= addr_i)
//  fifo_rdata_o    out  32        = instr_rdata_i
//  fifo_err_o      out  1         = instr_err_i
//  instr_req_o     out  1         bus request
//  instr_gnt_i     in   1         bus grant
//  instr_addr_o    out  32        bus address, [1:0]=2'b00
//  instr_rvalid_i  in   1         bus response valid (in order, >=1 cycle after gnt)
//  instr_rdata_i   in   32        bus response data
//  instr_err_i     in   1         bus response error
// BEHAVIOUR
//  Reset: instr_req_o=0, instr_addr_o=0, fifo_valid_o=0, busy_o=0, fetch_addr_q=0, all tracking bits 0.
//  Clock/reset: single clock clk_i; reset rst_ni is asynchronous, active low.
//  Tracking: rdata_outstanding_q[NUM_REQS] and discard_q[NUM_REQS], shift-register ordered;
//   bit 0 = oldest. Push on gnt at lowest free slot. Shift down on rvalid.
//  Slot allowance (capacity): new request allowed iff outstanding count < NUM_REQS and
//   outstanding + popcount(fifo_busy_i) < NUM_REQS; fifo_busy_i is ignored when branch_i=1.
//  Request FSM, states IDLE / WAIT_GNT:
//   IDLE: instr_req_o = req_i & slot_allowance.
//    Address = branch_i ? {addr_i[31:2],2'b00} : fetch_addr_q.
//    gnt that cycle -> stay IDLE; else -> WAIT_GNT, latching address into stored_addr_q.
//   WAIT_GNT: instr_req_o=1 and instr_addr_o=stored_addr_q held stable regardless of req_i/branch_i
//    (OBI rule; no retraction). gnt -> IDLE.
//  Address arithmetic: on gnt, fetch_addr_q <= granted addr + 4 (32-bit wrap, 0xFFFFFFFC -> 0).
//   On branch_i, fetch_addr_q <= {addr_i[31:2],2'b00}; a branch wins over a same-cycle gnt update.
//   If branch_i fires in WAIT_GNT: the new target is saved and issued after the pending gnt.
//  Discard: branch_i sets discard_q on every outstanding slot. A WAIT_GNT request granted after a
//   branch is marked discard. A request issued in the branch cycle is not discarded.
//  Responses: fifo_valid_o = instr_rvalid_i & ~discard_q[0] & ~branch_i. Latency 0 (combinational).
//   rvalid with no outstanding request is illegal (assert).
//  Same cycle gnt+rvalid: shift, then push; count unchanged.
//  Sequencing: req_i low stops new requests only; outstanding responses are still accepted.
//  busy_o = |rdata_outstanding_q | instr_req_o.
//  Reset mid-operation clears all state; the bus agent is reset together with the core.
// STRUCTURE
//  No new package types; NUM_REQS is passed from the IF stage with the FIFO.
//  Natural sub-module: cve2_fetch_outstanding_trk (outstanding/discard shift registers, count).
//  The FSM and address logic stay in this module.
//  Assertions: instr_req_o stable until gnt; no FIFO push when full; outstanding <= NUM_REQS.
// TESTING
//  1 Reset, req_i=1, branch to 0x80, gnt every cycle, rvalid 1 cycle later
//    -> addrs 0x80,0x84,0x88; FIFO pushes in order.
//  2 gnt held low 3 cycles on 0x100 with branch to 0x200 in cycle 2 -> addr stays 0x100 until gnt;
//    its response not pushed; next request is 0x200.
//  3 NUM_REQS=2, gnt always, rvalid withheld -> exactly 2 grants, then instr_req_o=0
//    until the first rvalid.
//  4 fifo_busy_i=2'b11, no outstanding -> instr_req_o=0; branch_i same cycle -> request to target issued.
//  5 Branch to 0x3 -> instr_addr_o=0x0, fifo_addr_o=0x3. Fetch at 0xFFFFFFFC granted -> next addr 0x0.
//  6 rvalid with instr_err_i=1 -> fifo_valid_o=1, fifo_err_o=1. Reset asserted mid-burst
//    -> all outputs 0 next edge.

Source files
------------

// File: rtl/cve2_fetch_req_ctrl_pkg.sv
// Shared definitions for the instruction fetch request controller.
package cve2_fetch_req_ctrl_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam logic [31:0] ADDR_STEP = 32'd4;

  typedef enum logic {
    IDLE,
    WAIT_GNT
  } fetch_state_e;

  // Number of set bits in a zero-extended occupancy/tracking vector.
  function automatic logic [31:0] count_ones(input logic [31:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cve2_fetch_outstanding_trk.sv
// Outstanding-transaction and discard tracking for in-order bus responses.
// Slot 0 is always the oldest transaction; occupancy is contiguous from slot 0.
module cve2_fetch_outstanding_trk
  import cve2_fetch_req_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_REQS = 2,
  localparam int unsigned CNT_W    = $clog2(NUM_REQS + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic                push_discard_i,
  input  logic                pop_i,
  input  logic                branch_i,
  output logic [NUM_REQS-1:0] outstanding_o,
  output logic                discard_oldest_o,
  output logic [CNT_W-1:0]    count_c
);

  logic [NUM_REQS-1:0] outstanding_q, outstanding_d;
  logic [NUM_REQS-1:0] discard_q, discard_d;
  logic [NUM_REQS-1:0] disc_br, out_sh, disc_sh, new_slot;

  // Branch marks everything in flight, then shift on response, then push on grant.
  always_comb begin
    disc_br       = branch_i ? (discard_q | outstanding_q) : discard_q;
    out_sh        = pop_i ? (outstanding_q >> 1) : outstanding_q;
    disc_sh       = pop_i ? (disc_br >> 1) : disc_br;
    new_slot      = push_i ? (~out_sh & ((out_sh << 1) | NUM_REQS'(1))) : '0;
    outstanding_d = out_sh | new_slot;
    discard_d     = disc_sh | (push_discard_i ? new_slot : '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign outstanding_o    = outstanding_q;
  assign discard_oldest_o = discard_q[0];
  assign count_c          = CNT_W'(count_ones(32'(outstanding_q)));

endmodule

// File: rtl/cve2_fetch_req_ctrl.sv
// IF-stage fetch request sequencer: issues word-aligned OBI requests, bounds
// outstanding transactions and forwards non-discarded responses to the fetch FIFO.
module cve2_fetch_req_ctrl
  import cve2_fetch_req_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_REQS = 2,
  localparam int unsigned CNT_W    = $clog2(NUM_REQS + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [ADDR_W-1:0]   addr_i,
  output logic                busy_o,
  output logic                fifo_clear_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_valid_o,
  output logic [ADDR_W-1:0]   fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [ADDR_W-1:0]   instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i
);

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0]   stored_addr_q, stored_addr_d;
  logic                branch_pend_q, branch_pend_d;
  logic [ADDR_W-1:0]   branch_addr, idle_addr;
  logic [31:0]         fifo_occ, out_cnt;
  logic                slot_allow, push_discard;
  logic [NUM_REQS-1:0] outstanding;
  logic                discard_oldest;
  logic [CNT_W-1:0]    count;

  assign branch_addr = {addr_i[31:2], 2'b00};
  assign idle_addr   = branch_i ? branch_addr : fetch_addr_q;

  // A branch clears the FIFO, so its occupancy no longer limits new requests.
  always_comb begin
    out_cnt    = 32'(count);
    fifo_occ   = branch_i ? '0 : count_ones(32'(fifo_busy_i));
    slot_allow = (out_cnt < NUM_REQS) && ((out_cnt + fifo_occ) < NUM_REQS);
  end

  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    stored_addr_d = stored_addr_q;
    branch_pend_d = branch_pend_q;
    push_discard  = 1'b0;
    instr_req_o   = 1'b0;
    instr_addr_o  = fetch_addr_q;

    unique case (state_q)
      IDLE: begin
        instr_addr_o  = idle_addr;
        instr_req_o   = req_i & slot_allow;
        branch_pend_d = 1'b0;
        if (branch_i) begin
          fetch_addr_d = branch_addr;
        end
        if (instr_req_o) begin
          if (instr_gnt_i) begin
            fetch_addr_d = idle_addr + ADDR_STEP;
          end else begin
            state_d       = WAIT_GNT;
            stored_addr_d = idle_addr;
          end
        end
      end
      WAIT_GNT: begin
        // Request may not be retracted or altered; a branch is deferred.
        instr_req_o  = 1'b1;
        instr_addr_o = stored_addr_q;
        if (branch_i) begin
          fetch_addr_d  = branch_addr;
          branch_pend_d = 1'b1;
        end
        if (instr_gnt_i) begin
          state_d       = IDLE;
          push_discard  = branch_pend_q | branch_i;
          branch_pend_d = 1'b0;
          if (!branch_pend_q && !branch_i) begin
            fetch_addr_d = stored_addr_q + ADDR_STEP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      fetch_addr_q  <= '0;
      stored_addr_q <= '0;
      branch_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      stored_addr_q <= stored_addr_d;
      branch_pend_q <= branch_pend_d;
    end
  end

  cve2_fetch_outstanding_trk #(
    .NUM_REQS(NUM_REQS)
  ) u_trk (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .push_i          (instr_req_o & instr_gnt_i),
    .push_discard_i  (push_discard),
    .pop_i           (instr_rvalid_i),
    .branch_i        (branch_i),
    .outstanding_o   (outstanding),
    .discard_oldest_o(discard_oldest),
    .count_c         (count)
  );

  assign fifo_valid_o = instr_rvalid_i & ~discard_oldest & ~branch_i;
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign busy_o       = (|outstanding) | instr_req_o;

  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (instr_req_o && !instr_gnt_i) |=> (instr_req_o && $stable(instr_addr_o)));
  a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> outstanding[0]);
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_valid_o |-> !(&fifo_busy_i));
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(count) <= NUM_REQS);

endmodule
